branch_resolve_unit: RTL and testbench

- Consumer side of the branch-prediction interface: captures the IF-stage prediction, carries it through ID to EX, and compares it with the actual outcome in EX.
- Generates the pipeline flush/redirect and the predictor update strobe (enable, taken, PC) that the predictor consumes.
- Also keeps saturating branch and mispredict statistics counters.
- Sits beside the EX stage of the 5-stage pipelined core.

---
 rtl/branch_pkg.sv | 19 +
 rtl/sat_counter_stat.sv | 19 +
 rtl/branch_resolve_unit.sv | 101 ++++++++++
 tb/tb_branch_resolve_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types for the branch resolve slice: per-stage prediction metadata
// carried IF->ID->EX, and the resolve FSM encoding.
package branch_pkg;

  localparam int XLEN    = 32;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic            pred_taken;
  } br_meta_t;

  typedef enum logic {
    BR_RUN     = 1'b0,
    BR_RECOVER = 1'b1
  } br_state_t;

endpackage

// File: rtl/sat_counter_stat.sv
// Saturating event counter: increments on inc, sticks at all-ones.
module sat_counter_stat #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Carries IF-stage predictions to EX, resolves them against the actual
// outcome, drives flush/redirect and the predictor update strobe.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN      = branch_pkg::XLEN,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 stall,
  input  logic                 valid_IF,
  input  logic [XLEN-1:0]      PC_IF,
  input  logic                 predict_taken_IF,
  input  logic                 is_br_EX,
  input  logic                 branch_taken_EX,
  input  logic [XLEN-1:0]      target_EX,
  output logic                 br_flush,
  output logic [XLEN-1:0]      redirect_pc,
  output logic                 upd_en,
  output logic                 upd_taken,
  output logic [XLEN-1:0]      upd_pc,
  output logic [CNT_WIDTH-1:0] br_count,
  output logic [CNT_WIDTH-1:0] mispred_count,
  output br_state_t            dbg_state
);

  // Handshake: there is no ready path. upd_en / br_flush are single-cycle
  // strobes, valid only while stall=0; the consumer must act on every one.

  br_meta_t  id_q, ex_q;
  br_state_t state_q, state_d;
  logic      resolve_ok;
  logic      mispredict;
  logic      phantom;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BR_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BR_RUN:     if (br_flush) state_d = BR_RECOVER;
      BR_RECOVER: if (!stall)   state_d = BR_RUN;
      default:    state_d = BR_RUN;
    endcase
  end

  // Flush turns both younger slots into bubbles instead of advancing them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      id_q <= '0;
      ex_q <= '0;
    end else if (!stall) begin
      if (br_flush) begin
        id_q <= '0;
        ex_q <= '0;
      end else begin
        id_q <= '{valid: valid_IF, pc: PC_IF, pred_taken: predict_taken_IF};
        ex_q <= id_q;
      end
    end
  end

  always_comb begin
    resolve_ok  = !stall && ex_q.valid && (state_q == BR_RUN);
    mispredict  = resolve_ok && is_br_EX && (ex_q.pred_taken != branch_taken_EX);
    phantom     = resolve_ok && !is_br_EX && ex_q.pred_taken;
    br_flush    = mispredict || phantom;
    redirect_pc = '0;
    if (br_flush) begin
      redirect_pc = (is_br_EX && branch_taken_EX) ? target_EX
                                                  : ex_q.pc + XLEN'(PC_STEP);
    end
    upd_en    = resolve_ok && is_br_EX;
    upd_taken = upd_en ? branch_taken_EX : 1'b0;
    upd_pc    = upd_en ? ex_q.pc : '0;
  end

  assign dbg_state = state_q;

  sat_counter_stat #(.WIDTH(CNT_WIDTH)) u_br_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (upd_en),
    .count   (br_count)
  );

  sat_counter_stat #(.WIDTH(CNT_WIDTH)) u_mispred_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (br_flush),
    .count   (mispred_count)
  );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit; a narrow-counter twin shares the
// stimulus to show saturation.
module tb_branch_resolve_unit;
  import branch_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        valid_IF;
  logic [31:0] PC_IF;
  logic        predict_taken_IF;
  logic        is_br_EX;
  logic        branch_taken_EX;
  logic [31:0] target_EX;

  logic        br_flush, upd_en, upd_taken;
  logic [31:0] redirect_pc, upd_pc;
  logic [15:0] br_count, mispred_count;
  br_state_t   dbg_state;

  logic        s_br_flush, s_upd_en, s_upd_taken;
  logic [31:0] s_redirect_pc, s_upd_pc;
  logic [3:0]  s_br_count, s_mispred_count;
  br_state_t   s_dbg_state;

  logic [31:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  branch_resolve_unit u_dut (
    .clk (clk), .reset_n (reset_n), .stall (stall),
    .valid_IF (valid_IF), .PC_IF (PC_IF), .predict_taken_IF (predict_taken_IF),
    .is_br_EX (is_br_EX), .branch_taken_EX (branch_taken_EX), .target_EX (target_EX),
    .br_flush (br_flush), .redirect_pc (redirect_pc), .upd_en (upd_en),
    .upd_taken (upd_taken), .upd_pc (upd_pc), .br_count (br_count),
    .mispred_count (mispred_count), .dbg_state (dbg_state)
  );

  branch_resolve_unit #(.CNT_WIDTH(4)) u_small (
    .clk (clk), .reset_n (reset_n), .stall (stall),
    .valid_IF (valid_IF), .PC_IF (PC_IF), .predict_taken_IF (predict_taken_IF),
    .is_br_EX (is_br_EX), .branch_taken_EX (branch_taken_EX), .target_EX (target_EX),
    .br_flush (s_br_flush), .redirect_pc (s_redirect_pc), .upd_en (s_upd_en),
    .upd_taken (s_upd_taken), .upd_pc (s_upd_pc), .br_count (s_br_count),
    .mispred_count (s_mispred_count), .dbg_state (s_dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    is_br_EX        = 1'b0;
    branch_taken_EX = 1'b0;
    target_EX       = 32'h0;
  endtask

  // One instruction into IF, then two cycles so it sits in EX.
  task automatic issue(input logic [31:0] pc, input logic pred);
    clear_ex();
    valid_IF         = 1'b1;
    PC_IF            = pc;
    predict_taken_IF = pred;
    tick();
    valid_IF         = 1'b0;
    PC_IF            = 32'h0;
    predict_taken_IF = 1'b0;
    tick();
  endtask

  task automatic drive_ex(input logic br, input logic tk, input logic [31:0] tgt);
    is_br_EX        = br;
    branch_taken_EX = tk;
    target_EX       = tgt;
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    stall = 1'b0;
    valid_IF = 1'b0;
    PC_IF = 32'h0;
    predict_taken_IF = 1'b0;
    clear_ex();
    tick();
    tick();
    check("rst_flush", 32'(br_flush), 32'h0);
    check("rst_redirect", redirect_pc, 32'h0);
    check("rst_upd_en", 32'(upd_en), 32'h0);
    check("rst_br_count", 32'(br_count), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(BR_RUN));
    reset_n = 1'b1;

    // correct taken prediction
    issue(32'h100, 1'b1);
    exp_q.push_back(32'h100);
    drive_ex(1'b1, 1'b1, 32'h180);
    check("t1_flush", 32'(br_flush), 32'h0);
    check("t1_upd_en", 32'(upd_en), 32'h1);
    check("t1_upd_pc", upd_pc, exp_q.pop_front());
    check("t1_upd_taken", 32'(upd_taken), 32'h1);
    tick();
    check("t1_br_count", 32'(br_count), 32'd1);
    check("t1_mispred", 32'(mispred_count), 32'd0);

    // predicted not-taken, actually taken
    issue(32'h200, 1'b0);
    exp_q.push_back(32'h200);
    drive_ex(1'b1, 1'b1, 32'h80);
    check("t2_flush", 32'(br_flush), 32'h1);
    check("t2_redirect", redirect_pc, 32'h80);
    check("t2_upd_en", 32'(upd_en), 32'h1);
    check("t2_upd_pc", upd_pc, exp_q.pop_front());
    tick();
    check("t2_state", 32'(dbg_state), 32'(BR_RECOVER));
    check("t2_rec_flush", 32'(br_flush), 32'h0);
    check("t2_rec_upd_en", 32'(upd_en), 32'h0);
    check("t2_mispred", 32'(mispred_count), 32'd1);
    check("t2_br_count", 32'(br_count), 32'd2);

    // phantom taken on a non-branch
    issue(32'h300, 1'b1);
    check("t3_state_run", 32'(dbg_state), 32'(BR_RUN));
    drive_ex(1'b0, 1'b0, 32'h0);
    check("t3_flush", 32'(br_flush), 32'h1);
    check("t3_redirect", redirect_pc, 32'h304);
    check("t3_upd_en", 32'(upd_en), 32'h0);
    tick();
    check("t3_br_count", 32'(br_count), 32'd2);
    check("t3_mispred", 32'(mispred_count), 32'd2);

    // mispredict held under stall for three cycles
    issue(32'h400, 1'b0);
    exp_q.push_back(32'h400);
    stall = 1'b1;
    drive_ex(1'b1, 1'b1, 32'h500);
    for (int i = 0; i < 3; i++) begin
      check("t4_stall_flush", 32'(br_flush), 32'h0);
      check("t4_stall_upd_en", 32'(upd_en), 32'h0);
      tick();
    end
    check("t4_stall_br_count", 32'(br_count), 32'd2);
    stall = 1'b0;
    #1;
    check("t4_flush", 32'(br_flush), 32'h1);
    check("t4_upd_en", 32'(upd_en), 32'h1);
    check("t4_redirect", redirect_pc, 32'h500);
    check("t4_upd_pc", upd_pc, exp_q.pop_front());
    tick();
    check("t4_br_count", 32'(br_count), 32'd3);
    check("t4_mispred", 32'(mispred_count), 32'd3);

    // PC wrap on fall-through redirect
    issue(32'hFFFF_FFFC, 1'b1);
    drive_ex(1'b0, 1'b0, 32'h0);
    check("t5_flush", 32'(br_flush), 32'h1);
    check("t5_redirect_wrap", redirect_pc, 32'h0);
    tick();
    check("t5_mispred", 32'(mispred_count), 32'd4);

    // 16 more phantoms: 20 total, narrow counter pins at 15
    for (int i = 0; i < 16; i++) begin
      issue(32'h1000 + 32'(i) * 32'h10, 1'b1);
      drive_ex(1'b0, 1'b0, 32'h0);
      tick();
    end
    check("t5_mispred_20", 32'(mispred_count), 32'd20);
    check("t5_small_sat", 32'(s_mispred_count), 32'd15);
    check("t5_small_br", 32'(s_br_count), 32'd3);

    // async reset while a flush is being driven
    issue(32'h600, 1'b0);
    drive_ex(1'b1, 1'b1, 32'h700);
    check("t6_pre_flush", 32'(br_flush), 32'h1);
    reset_n = 1'b0;
    #1;
    check("t6_flush", 32'(br_flush), 32'h0);
    check("t6_redirect", redirect_pc, 32'h0);
    check("t6_upd_en", 32'(upd_en), 32'h0);
    check("t6_upd_pc", upd_pc, 32'h0);
    check("t6_br_count", 32'(br_count), 32'h0);
    check("t6_mispred", 32'(mispred_count), 32'h0);
    tick();
    reset_n = 1'b1;
    check("t6_state", 32'(dbg_state), 32'(BR_RUN));
    tick();
    check("t6_post_flush", 32'(br_flush), 32'h0);
    issue(32'h800, 1'b1);
    exp_q.push_back(32'h800);
    drive_ex(1'b1, 1'b1, 32'h900);
    check("t6_new_flush", 32'(br_flush), 32'h0);
    check("t6_new_upd_en", 32'(upd_en), 32'h1);
    check("t6_new_upd_pc", upd_pc, exp_q.pop_front());
    tick();
    check("t6_new_br_count", 32'(br_count), 32'd1);
    clear_ex();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
